// File: rtl/mux16_rr_arbiter_pkg.sv
// Shared sizes and state encoding for the mux16 round-robin arbiter.
package mux16_rr_arbiter_pkg;
   localparam int N_CH  = 16;
   localparam int SEL_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_GAP  = 2'd2
   } state_e;
endpackage

// File: rtl/mux16_rr_arbiter_if.sv
// Requester bank <-> arbiter bundle: requests, data bits, grant and mux output.
interface mux16_rr_arbiter_if;
   import mux16_rr_arbiter_pkg::*;

   logic [N_CH-1:0]  req;
   logic [N_CH-1:0]  din;
   logic [N_CH-1:0]  gnt;
   logic             gnt_valid;
   logic [SEL_W-1:0] sel;
   logic             dout;
   logic             timeout;

   modport master (
      output req, din,
      input  gnt, gnt_valid, sel, dout, timeout
   );

   modport slave (
      input  req, din,
      output gnt, gnt_valid, sel, dout, timeout
   );
endinterface

// File: rtl/mux16_rr_arbiter_mux.sv
// Plain combinational 16:1 bit selector feeding the dout register.
module mux_16x1
   import mux16_rr_arbiter_pkg::*;
(
   input  logic [N_CH-1:0]  din_i,
   input  logic [SEL_W-1:0] sel_i,
   output logic             dout_o
);
   assign dout_o = din_i[sel_i];
endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter driving the select of a 16:1 bit mux.
module mux16_rr_arbiter
   import mux16_rr_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 8
) (
   input logic                clk_i,
   input logic                rst_i,
   mux16_rr_arbiter_if.slave  arb_io
);
   localparam bit HOLD_EN = (MAX_HOLD != 0);
   localparam logic [CNT_W-1:0] HOLD_LAST =
      CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

   state_e           state_q, state_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N_CH-1:0]  gnt_q, gnt_d;
   logic             gv_q, gv_d;
   logic             dout_q, dout_d;
   logic             to_q, to_d;
   logic [SEL_W:0]   pick;
   logic             mux_bit;
   logic             hold_last;

   // Rotate so ptr sits at bit 0, take lowest set bit, rotate back.
   function automatic logic [SEL_W:0] rr_pick(
      input logic [N_CH-1:0]  r,
      input logic [SEL_W-1:0] p
   );
      logic [N_CH-1:0] rot;
      logic [SEL_W:0]  res;
      rot = N_CH'({r, r} >> p);
      res = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (rot[i]) res = {1'b1, SEL_W'(i) + p};
      end
      return res;
   endfunction

   mux_16x1 u_mux (
      .din_i  (arb_io.din),
      .sel_i  (sel_q),
      .dout_o (mux_bit)
   );

   assign hold_last = HOLD_EN && (cnt_q == HOLD_LAST);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      gv_d    = gv_q;
      dout_d  = dout_q;
      to_d    = 1'b0;
      pick    = rr_pick(arb_io.req, ptr_q);
      unique case (state_q)
         ST_IDLE: begin
            if (pick[SEL_W]) begin
               state_d = ST_BUSY;
               sel_d   = pick[SEL_W-1:0];
               ptr_d   = pick[SEL_W-1:0] + 1'b1;
               gnt_d   = N_CH'(1) << pick[SEL_W-1:0];
               gv_d    = 1'b1;
               cnt_d   = '0;
               dout_d  = 1'b0;
            end
         end
         ST_BUSY: begin
            if (!arb_io.req[sel_q] || hold_last) begin
               // Release beats timeout: pulse only if still requesting.
               state_d = ST_GAP;
               gnt_d   = '0;
               gv_d    = 1'b0;
               dout_d  = 1'b0;
               to_d    = arb_io.req[sel_q];
            end else begin
               dout_d = mux_bit;
               if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            end
         end
         ST_GAP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         gv_q    <= 1'b0;
         dout_q  <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         gv_q    <= gv_d;
         dout_q  <= dout_d;
         to_q    <= to_d;
      end
   end

   assign arb_io.gnt       = gnt_q;
   assign arb_io.gnt_valid = gv_q;
   assign arb_io.sel       = sel_q;
   assign arb_io.dout      = dout_q;
   assign arb_io.timeout   = to_q;
endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Bench for mux16_rr_arbiter: limited (8) and unlimited hold instances vs a behavioural model.
module tb_mux16_rr_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] req = '0;
   logic [15:0] din = '0;
   logic [15:0] r   = '0;
   bit          chk_en = 1'b0;
   int          n_cmp = 0;
   int          n_err = 0;

   mux16_rr_arbiter_if ia ();
   mux16_rr_arbiter_if ib ();

   assign ia.req = req;
   assign ia.din = din;
   assign ib.req = req;
   assign ib.din = din;

   mux16_rr_arbiter #(.MAX_HOLD(8), .CNT_W(8)) u_dut_a (
      .clk_i  (clk),
      .rst_i  (rst),
      .arb_io (ia)
   );

   mux16_rr_arbiter #(.MAX_HOLD(0), .CNT_W(8)) u_dut_b (
      .clk_i  (clk),
      .rst_i  (rst),
      .arb_io (ib)
   );

   always #5 clk = ~clk;

   // Model: who owns the line, for how many cycles, where the scan starts.
   int m_mh   [2] = '{8, 0};
   bit m_busy [2];
   bit m_gap  [2];
   bit m_to   [2];
   bit m_dout [2];
   int m_own  [2];
   int m_ptr  [2];
   int m_held [2];

   task automatic model_step(input int k);
      int w;
      m_to[k] = 1'b0;
      if (rst) begin
         m_busy[k] = 0; m_gap[k] = 0; m_dout[k] = 0;
         m_own[k] = 0; m_ptr[k] = 0; m_held[k] = 0;
      end else if (m_gap[k]) begin
         m_gap[k] = 0;
      end else if (m_busy[k]) begin
         if (!req[m_own[k]]) begin
            m_busy[k] = 0; m_gap[k] = 1; m_dout[k] = 0;
         end else if (m_mh[k] != 0 && m_held[k] == m_mh[k]) begin
            m_busy[k] = 0; m_gap[k] = 1; m_dout[k] = 0; m_to[k] = 1;
         end else begin
            m_held[k] = m_held[k] + 1;
            m_dout[k] = din[m_own[k]];
         end
      end else begin
         w = -1;
         for (int j = 0; j < 16; j++)
            if (w < 0 && req[(m_ptr[k] + j) % 16]) w = (m_ptr[k] + j) % 16;
         if (w >= 0) begin
            m_busy[k] = 1; m_own[k] = w; m_ptr[k] = (w + 1) % 16;
            m_held[k] = 1; m_dout[k] = 0;
         end
      end
   endtask

   always @(posedge clk) begin
      model_step(0);
      model_step(1);
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
      end
   endtask

   task automatic cmp(input int k, input logic [15:0] g, input logic gv,
                      input logic [3:0] s, input logic d, input logic to);
      logic [15:0] eg;
      eg = m_busy[k] ? (16'h0001 << m_own[k]) : 16'h0000;
      chk($sformatf("m%0d_gnt", k), 32'(g), 32'(eg));
      chk($sformatf("m%0d_gnt_valid", k), 32'(gv), 32'(m_busy[k]));
      if (m_busy[k]) chk($sformatf("m%0d_sel", k), 32'(s), 32'(m_own[k]));
      chk($sformatf("m%0d_dout", k), 32'(d), 32'(m_dout[k]));
      chk($sformatf("m%0d_timeout", k), 32'(to), 32'(m_to[k]));
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp(0, ia.gnt, ia.gnt_valid, ia.sel, ia.dout, ia.timeout);
         cmp(1, ib.gnt, ib.gnt_valid, ib.sel, ib.dout, ib.timeout);
      end
   end

   task automatic step(input logic [15:0] rq, input logic [15:0] d);
      req = rq;
      din = d;
      @(posedge clk);
      #1;
   endtask

   bit ga [12];
   bit ta [12];
   bit gb [12];
   int cnt;

   initial begin
      // Reset with every channel requesting.
      rst = 1'b1;
      step(16'hFFFF, 16'hFFFF);
      chk_en = 1'b1;
      step(16'hFFFF, 16'hFFFF);
      chk("rst_gnt", 32'(ia.gnt), 32'h0);
      chk("rst_gv", 32'(ia.gnt_valid), 32'h0);
      chk("rst_sel", 32'(ia.sel), 32'h0);
      chk("rst_dout", 32'(ia.dout), 32'h0);
      chk("rst_to", 32'(ia.timeout), 32'h0);
      rst = 1'b0;
      step(16'h0000, 16'h0000);

      // Single requester on channel 5; dout lags din[5].
      step(16'h0020, 16'h0020);
      chk("single_sel", 32'(ia.sel), 32'd5);
      chk("single_gnt", 32'(ia.gnt), 32'h0020);
      chk("single_dout0", 32'(ia.dout), 32'h0);
      step(16'h0020, 16'hFFDF);
      chk("single_dout_lo", 32'(ia.dout), 32'h0);
      step(16'h0020, 16'h0020);
      chk("single_dout_hi", 32'(ia.dout), 32'h1);
      step(16'h0020, 16'hFFDF);
      step(16'h0000, 16'hFFFF);
      chk("single_gap_gv", 32'(ia.gnt_valid), 32'h0);
      chk("single_gap_dout", 32'(ia.dout), 32'h0);
      step(16'h0000, 16'h0000);

      // Two requesters alternating (ptr is 6 here, so 15 wins first).
      step(16'h8001, 16'h0);
      chk("rot_g1", 32'(ia.sel), 32'd15);
      step(16'h8001, 16'h0);
      step(16'h0001, 16'h0);
      step(16'h8001, 16'h0);
      step(16'h8001, 16'h0);
      chk("rot_g2", 32'(ib.sel), 32'd0);
      step(16'h8001, 16'h0);
      step(16'h8000, 16'h0);
      step(16'h8001, 16'h0);
      step(16'h8001, 16'h0);
      chk("rot_g3", 32'(ia.sel), 32'd15);
      step(16'h8001, 16'h0);
      step(16'h0001, 16'h0);
      step(16'h8001, 16'h0);
      step(16'h8001, 16'h0);
      chk("rot_g4", 32'(ia.sel), 32'd0);
      step(16'h8001, 16'h0);
      step(16'h8000, 16'h0);
      step(16'h0000, 16'h0);

      // Pointer wrap: grant 14 leaves ptr at 15.
      step(16'h4000, 16'h0);
      chk("wrap_g14", 32'(ia.sel), 32'd14);
      step(16'h4003, 16'h0);
      chk("wrap_nopreempt", 32'(ia.gnt), 32'h4000);
      step(16'h0003, 16'h0);
      step(16'h0003, 16'h0);
      step(16'h0003, 16'h0);
      chk("wrap_g0", 32'(ia.sel), 32'd0);
      step(16'h0002, 16'h0);
      step(16'h0002, 16'h0);
      step(16'h0002, 16'h0);
      chk("wrap_g1", 32'(ia.sel), 32'd1);
      step(16'h0000, 16'h0);
      step(16'h0000, 16'h0);

      // Channel 2 never releases: limit of 8 vs unlimited.
      for (int i = 1; i <= 11; i++) begin
         step(16'h0004, 16'($urandom));
         ga[i] = ia.gnt_valid;
         ta[i] = ia.timeout;
         gb[i] = ib.gnt_valid;
      end
      cnt = 0;
      for (int i = 1; i <= 8; i++) cnt += int'(ga[i]);
      chk("to_busy_len", 32'(cnt), 32'd8);
      chk("to_gap_gv", 32'(ga[9]), 32'h0);
      chk("to_pulse_pos", 32'(ta[9]), 32'h1);
      cnt = 0;
      for (int i = 1; i <= 11; i++) cnt += int'(ta[i]);
      chk("to_pulse_cnt", 32'(cnt), 32'd1);
      chk("to_regrant", 32'(ga[11]), 32'h1);
      chk("to_regrant_sel", 32'(ia.sel), 32'd2);
      cnt = 0;
      for (int i = 1; i <= 11; i++) cnt += int'(gb[i]);
      chk("nolimit_len", 32'(cnt), 32'd11);

      // Reset in the middle of a grant to channel 9.
      step(16'h0000, 16'h0);
      step(16'h0000, 16'h0);
      step(16'h0200, 16'h0);
      step(16'h0200, 16'h0200);
      chk("mid_sel9", 32'(ia.sel), 32'd9);
      rst = 1'b1;
      step(16'h0200, 16'h0);
      chk("mid_rst_gv", 32'(ia.gnt_valid), 32'h0);
      chk("mid_rst_gnt", 32'(ib.gnt), 32'h0);
      chk("mid_rst_to", 32'(ia.timeout), 32'h0);
      rst = 1'b0;
      step(16'h0201, 16'h0);
      chk("mid_after_sel", 32'(ia.sel), 32'd0);
      step(16'h0201, 16'h0);
      rst = 1'b1;
      step(16'h8001, 16'h0);
      rst = 1'b0;
      step(16'h8001, 16'h0);
      chk("mid_ptr_clr", 32'(ia.sel), 32'd0);
      step(16'h0000, 16'h0);

      // Mixed traffic, requests held for random stretches.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) r = 16'($urandom) & 16'($urandom);
         rst = ($urandom_range(0, 99) == 0);
         step(r, 16'($urandom));
      end
      rst = 1'b0;
      step(16'h0000, 16'h0);
      step(16'h0000, 16'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
